// File: rtl/teclado_atm.sv
// Keypad front-end for the ATM controller.
// Synchronises and debounces the raw keypad strobe. In PIN mode it emits
// single digits. In amount mode it accumulates decimal keys into a 32-bit
// amount and commits that amount when ENTER is pressed.
module teclado_atm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        modo_monto,
  input  logic        tecla_activa,
  input  logic [3:0]  tecla,
  output logic        digito_stb,
  output logic [3:0]  digito,
  output logic        monto_stb,
  output logic [31:0] monto,
  output logic [3:0]  digitos_cnt,
  output logic        entrada_error
);

  localparam logic [3:0] DB_N  = DEBOUNCE_CYCLES[3:0];
  localparam logic [3:0] MAX_D = MAX_DIGITS[3:0];
  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} db_state_t;

  db_state_t   state, state_nxt;
  logic [3:0]  cnt_db, cnt_db_nxt;
  logic        sync1, act_s;
  logic        press_evt;
  logic        mode_q, mode_chg;
  logic [31:0] acc, acc_nxt, acc_base;
  logic [3:0]  dcnt_base, dcnt_nxt;
  logic [3:0]  digito_nxt;
  logic [31:0] monto_nxt;
  logic        digito_stb_nxt, monto_stb_nxt, error_nxt;
  logic        is_digit;

  // Two-flop synchroniser for the asynchronous key-pressed level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      act_s <= 1'b0;
    end else begin
      sync1 <= tecla_activa;
      act_s <= sync1;
    end
  end

  // Debounce state and sample counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt_db <= 4'd0;
    end else begin
      state  <= state_nxt;
      cnt_db <= cnt_db_nxt;
    end
  end

  // Debounce next-state logic; a press is accepted once enough high samples are seen
  always_comb begin
    state_nxt  = state;
    cnt_db_nxt = cnt_db;
    press_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (act_s) begin
          state_nxt  = PRESS_CHK;
          cnt_db_nxt = 4'd1;
        end
      end
      PRESS_CHK: begin
        if (cnt_db == DB_N) begin
          press_evt = 1'b1;
          state_nxt = HELD;
        end else if (act_s) begin
          cnt_db_nxt = cnt_db + 4'd1;
        end else begin
          state_nxt  = IDLE;
          cnt_db_nxt = 4'd0;
        end
      end
      HELD: begin
        if (!act_s) begin
          state_nxt  = REL_CHK;
          cnt_db_nxt = 4'd1;
        end
      end
      REL_CHK: begin
        if (cnt_db == DB_N) begin
          state_nxt  = IDLE;
          cnt_db_nxt = 4'd0;
        end else if (!act_s) begin
          cnt_db_nxt = cnt_db + 4'd1;
        end else begin
          state_nxt = HELD;
        end
      end
      default: begin
        state_nxt  = IDLE;
        cnt_db_nxt = 4'd0;
      end
    endcase
  end

  assign mode_chg = (modo_monto != mode_q);
  assign is_digit = (tecla <= 4'd9);

  // Key decode: a mode change clears the accumulator first, then the key is decoded under the new mode
  always_comb begin
    acc_base       = mode_chg ? 32'd0 : acc;
    dcnt_base      = mode_chg ? 4'd0  : digitos_cnt;
    acc_nxt        = acc_base;
    dcnt_nxt       = dcnt_base;
    digito_nxt     = digito;
    monto_nxt      = monto;
    digito_stb_nxt = 1'b0;
    monto_stb_nxt  = 1'b0;
    error_nxt      = 1'b0;
    if (press_evt) begin
      if (!modo_monto) begin
        if (is_digit) begin
          digito_nxt     = tecla;
          digito_stb_nxt = 1'b1;
        end
      end else if (is_digit) begin
        if (dcnt_base < MAX_D) begin
          acc_nxt  = (acc_base << 3) + (acc_base << 1) + {28'd0, tecla};
          dcnt_nxt = dcnt_base + 4'd1;
        end else begin
          error_nxt = 1'b1;
        end
      end else if (tecla == KEY_ENTER) begin
        if (dcnt_base != 4'd0) begin
          monto_nxt     = acc_base;
          monto_stb_nxt = 1'b1;
          acc_nxt       = 32'd0;
          dcnt_nxt      = 4'd0;
        end else begin
          error_nxt = 1'b1;
        end
      end else if (tecla == KEY_CLEAR) begin
        acc_nxt  = 32'd0;
        dcnt_nxt = 4'd0;
      end
    end
  end

  // Accumulator, mode history and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= 1'b0;
      acc           <= 32'd0;
      digitos_cnt   <= 4'd0;
      digito        <= 4'd0;
      monto         <= 32'd0;
      digito_stb    <= 1'b0;
      monto_stb     <= 1'b0;
      entrada_error <= 1'b0;
    end else begin
      mode_q        <= modo_monto;
      acc           <= acc_nxt;
      digitos_cnt   <= dcnt_nxt;
      digito        <= digito_nxt;
      monto         <= monto_nxt;
      digito_stb    <= digito_stb_nxt;
      monto_stb     <= monto_stb_nxt;
      entrada_error <= error_nxt;
    end
  end

endmodule

// File: tb/tb_teclado_atm.sv
// Testbench for teclado_atm: directed key sequences with a scoreboard of expected pulses.
module tb_teclado_atm;

  logic        clk = 1'b0;
  logic        rst;
  logic        modo_monto;
  logic        tecla_activa;
  logic [3:0]  tecla;
  logic        digito_stb;
  logic [3:0]  digito;
  logic        monto_stb;
  logic [31:0] monto;
  logic [3:0]  digitos_cnt;
  logic        entrada_error;

  localparam int K_DIG = 0;
  localparam int K_MON = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];

  int          errors = 0;
  int          checks = 0;
  int          model_cnt = 0;
  logic [31:0] model_acc = 32'd0;
  logic [31:0] model_monto = 32'd0;
  logic        monitor_en = 1'b1;

  teclado_atm dut (
    .clk          (clk),
    .rst          (rst),
    .modo_monto   (modo_monto),
    .tecla_activa (tecla_activa),
    .tecla        (tecla),
    .digito_stb   (digito_stb),
    .digito       (digito),
    .monto_stb    (monto_stb),
    .monto        (monto),
    .digitos_cnt  (digitos_cnt),
    .entrada_error(entrada_error)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Reference behaviour of one accepted key, pushed as an expected pulse
  task automatic model_key(input logic [3:0] code);
    if (!modo_monto) begin
      if (code <= 4'd9) push_exp(K_DIG, {28'd0, code});
    end else if (code <= 4'd9) begin
      if (model_cnt < 9) begin
        model_acc = model_acc * 32'd10 + {28'd0, code};
        model_cnt++;
      end else begin
        push_exp(K_ERR, 32'd0);
      end
    end else if (code == 4'hA) begin
      if (model_cnt > 0) begin
        push_exp(K_MON, model_acc);
        model_monto = model_acc;
        model_acc   = 32'd0;
        model_cnt   = 0;
      end else begin
        push_exp(K_ERR, 32'd0);
      end
    end else if (code == 4'hB) begin
      model_acc = 32'd0;
      model_cnt = 0;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] code, input int hold, input int rel);
    model_key(code);
    @(negedge clk);
    tecla        = code;
    tecla_activa = 1'b1;
    repeat (hold) @(negedge clk);
    tecla_activa = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic set_mode(input logic m);
    @(negedge clk);
    modo_monto = m;
    model_acc  = 32'd0;
    model_cnt  = 0;
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard consumer: every output pulse must match the oldest expectation
  always @(negedge clk) begin
    if (monitor_en && !rst) begin
      if (digito_stb || monto_stb || entrada_error) begin
        exp_t e;
        int   kind;
        check_output("pulse_onehot", {31'd0, $onehot({digito_stb, monto_stb, entrada_error})}, 32'd1);
        kind = digito_stb ? K_DIG : (monto_stb ? K_MON : K_ERR);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_pulse: observed kind=%0d expected none", kind);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_output("pulse_kind", kind, e.kind);
          if (e.kind == K_DIG) check_output("digito", {28'd0, digito}, e.val);
          if (e.kind == K_MON) check_output("monto", monto, e.val);
        end
      end
    end
  end

  initial begin
    int pulse_cnt;
    int pulse_edge;
    rst          = 1'b1;
    modo_monto   = 1'b0;
    tecla_activa = 1'b0;
    tecla        = 4'd0;
    repeat (3) @(negedge clk);
    check_output("rst_digito_stb", {31'd0, digito_stb}, 32'd0);
    check_output("rst_digito", {28'd0, digito}, 32'd0);
    check_output("rst_monto_stb", {31'd0, monto_stb}, 32'd0);
    check_output("rst_monto", monto, 32'd0);
    check_output("rst_digitos_cnt", {28'd0, digitos_cnt}, 32'd0);
    check_output("rst_error", {31'd0, entrada_error}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: PIN digit latency");
    model_key(4'd7);
    pulse_cnt  = 0;
    pulse_edge = 0;
    tecla        = 4'd7;
    tecla_activa = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (digito_stb) begin
        pulse_cnt++;
        pulse_edge = i;
      end
    end
    @(negedge clk);
    tecla_activa = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (digito_stb) pulse_cnt++;
    end
    @(negedge clk);
    check_output("t1_pulse_count", pulse_cnt, 1);
    check_output("t1_pulse_edge", pulse_edge, 7);
    check_output("t1_digito_held", {28'd0, digito}, 32'd7);
    check_output("t1_monto_stb", {31'd0, monto_stb}, 32'd0);

    $display("[TB] test 2: short glitch");
    @(negedge clk);
    tecla        = 4'd3;
    tecla_activa = 1'b1;
    repeat (3) @(negedge clk);
    tecla_activa = 1'b0;
    repeat (10) @(negedge clk);
    apply_stimulus(4'd4, 8, 8);
    check_output("t2_digito_after", {28'd0, digito}, 32'd4);

    $display("[TB] test 3: amount 1250");
    set_mode(1'b1);
    apply_stimulus(4'd1, 8, 8);
    check_output("t3_cnt1", {28'd0, digitos_cnt}, 32'd1);
    apply_stimulus(4'd2, 8, 8);
    check_output("t3_cnt2", {28'd0, digitos_cnt}, 32'd2);
    apply_stimulus(4'd5, 8, 8);
    check_output("t3_cnt3", {28'd0, digitos_cnt}, 32'd3);
    apply_stimulus(4'd0, 8, 8);
    check_output("t3_cnt4", {28'd0, digitos_cnt}, 32'd4);
    apply_stimulus(4'hA, 8, 8);
    check_output("t3_monto", monto, 32'd1250);
    check_output("t3_cnt_after", {28'd0, digitos_cnt}, 32'd0);

    $display("[TB] test 4: digit overflow");
    for (int i = 0; i < 10; i++) apply_stimulus(4'd9, 8, 8);
    check_output("t4_cnt_full", {28'd0, digitos_cnt}, 32'd9);
    apply_stimulus(4'hA, 8, 8);
    check_output("t4_monto", monto, 32'd999999999);

    $display("[TB] test 5: empty enter and clear");
    apply_stimulus(4'hA, 8, 8);
    check_output("t5_monto_kept", monto, 32'd999999999);
    apply_stimulus(4'd4, 8, 8);
    apply_stimulus(4'd2, 8, 8);
    apply_stimulus(4'hB, 8, 8);
    check_output("t5_cnt_cleared", {28'd0, digitos_cnt}, 32'd0);
    apply_stimulus(4'd3, 8, 8);
    apply_stimulus(4'hE, 8, 8);
    check_output("t5_ignored_key", {28'd0, digitos_cnt}, 32'd1);
    apply_stimulus(4'hA, 8, 8);
    check_output("t5_monto", monto, 32'd3);

    $display("[TB] test 6: reset mid-entry");
    apply_stimulus(4'd5, 8, 8);
    apply_stimulus(4'd5, 8, 8);
    check_output("t6_cnt_before", {28'd0, digitos_cnt}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("t6_rst_monto", monto, 32'd0);
    check_output("t6_rst_cnt", {28'd0, digitos_cnt}, 32'd0);
    check_output("t6_rst_digito", {28'd0, digito}, 32'd0);
    check_output("t6_rst_pulses", {29'd0, digito_stb, monto_stb, entrada_error}, 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    model_acc   = 32'd0;
    model_cnt   = 0;
    model_monto = 32'd0;
    repeat (2) @(negedge clk);
    apply_stimulus(4'hA, 8, 8);
    check_output("t6_monto_zero", monto, model_monto);

    $display("[TB] test 7: mode change clears accumulator");
    apply_stimulus(4'd8, 8, 8);
    set_mode(1'b0);
    check_output("t7_cnt_cleared", {28'd0, digitos_cnt}, 32'd0);
    apply_stimulus(4'd6, 8, 8);
    check_output("t7_pin_digit", {28'd0, digito}, 32'd6);

    repeat (10) @(negedge clk);
    monitor_en = 1'b0;
    check_output("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
